// File: rtl/demux1to4_stream.sv
// demux1to4_stream: 1-to-4 packet demultiplexer with valid/ready handshake.
// Each output port owns a one-entry registered slot; select locks per packet.
module demux1to4_stream #(
   parameter int W = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_sel0,
   input  logic         i_sel1,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   input  logic         i_last,
   output logic         o_ready,
   output logic [W-1:0] o_y0,
   output logic [W-1:0] o_y1,
   output logic [W-1:0] o_y2,
   output logic [W-1:0] o_y3,
   output logic         o_valid0,
   output logic         o_valid1,
   output logic         o_valid2,
   output logic         o_valid3,
   output logic         o_last0,
   output logic         o_last1,
   output logic         o_last2,
   output logic         o_last3,
   input  logic         i_ready0,
   input  logic         i_ready1,
   input  logic         i_ready2,
   input  logic         i_ready3,
   output logic         o_busy,
   output logic [1:0]   o_dest
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t         state;
   logic [1:0]     target;
   logic [3:0]     rdy;
   logic [3:0]     vld_q;
   logic [3:0]     last_q;
   logic [3:0]     can_acc;
   logic [W-1:0]   y_q [4];
   logic           accept;

   assign rdy     = {i_ready3, i_ready2, i_ready1, i_ready0};
   assign target  = (state == LOCK) ? o_dest : {i_sel1, i_sel0};
   // a full slot frees up in the same cycle its consumer takes it
   assign can_acc = ~vld_q | rdy;
   assign o_ready = can_acc[target];
   assign accept  = i_valid & o_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_q  <= '0;
         last_q <= '0;
         for (int k = 0; k < 4; k++) begin
            y_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (accept && target == 2'(k)) begin
               y_q[k]    <= i_data;
               last_q[k] <= i_last;
               vld_q[k]  <= 1'b1;
            end else if (vld_q[k] && rdy[k]) begin
               vld_q[k]  <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         o_busy <= 1'b0;
         o_dest <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept && !i_last) begin
                  state  <= LOCK;
                  o_busy <= 1'b1;
                  o_dest <= target;
               end
            end
            LOCK: begin
               if (accept && i_last) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
                  o_dest <= 2'd0;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_dest <= 2'd0;
            end
         endcase
      end
   end

   assign o_y0     = y_q[0];
   assign o_y1     = y_q[1];
   assign o_y2     = y_q[2];
   assign o_y3     = y_q[3];
   assign o_valid0 = vld_q[0];
   assign o_valid1 = vld_q[1];
   assign o_valid2 = vld_q[2];
   assign o_valid3 = vld_q[3];
   assign o_last0  = last_q[0];
   assign o_last1  = last_q[1];
   assign o_last2  = last_q[2];
   assign o_last3  = last_q[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// tb_demux1to4_stream: directed and random stimulus against a port-slot
// reference model of the 1:4 packet demultiplexer.
module tb_demux1to4_stream;

   localparam int W = 2;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_sel0, i_sel1;
   logic [W-1:0] i_data;
   logic         i_valid, i_last;
   logic         o_ready;
   logic [W-1:0] o_y0, o_y1, o_y2, o_y3;
   logic         o_valid0, o_valid1, o_valid2, o_valid3;
   logic         o_last0, o_last1, o_last2, o_last3;
   logic         i_ready0, i_ready1, i_ready2, i_ready3;
   logic         o_busy;
   logic [1:0]   o_dest;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: one slot per port plus packet lock
   bit m_v [4];
   int m_y [4];
   bit m_l [4];
   bit m_lock;
   int m_dest;

   demux1to4_stream #(.W(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_sel0(i_sel0), .i_sel1(i_sel1),
      .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
      .o_ready(o_ready),
      .o_y0(o_y0), .o_y1(o_y1), .o_y2(o_y2), .o_y3(o_y3),
      .o_valid0(o_valid0), .o_valid1(o_valid1),
      .o_valid2(o_valid2), .o_valid3(o_valid3),
      .o_last0(o_last0), .o_last1(o_last1),
      .o_last2(o_last2), .o_last3(o_last3),
      .i_ready0(i_ready0), .i_ready1(i_ready1),
      .i_ready2(i_ready2), .i_ready3(i_ready3),
      .o_busy(o_busy), .o_dest(o_dest)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic [3:0] v;
      logic [3:0] l;
      logic [W-1:0] y [4];
      v = {o_valid3, o_valid2, o_valid1, o_valid0};
      l = {o_last3, o_last2, o_last1, o_last0};
      y[0] = o_y0; y[1] = o_y1; y[2] = o_y2; y[3] = o_y3;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("valid%0d", k), 32'(v[k]), 32'(m_v[k]));
         chk($sformatf("y%0d", k), 32'(y[k]), 32'(m_y[k]));
         chk($sformatf("last%0d", k), 32'(l[k]), 32'(m_l[k]));
      end
      chk("busy", 32'(o_busy), 32'(m_lock));
      chk("dest", 32'(o_dest), 32'(m_dest));
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_v[k] = 0;
         m_y[k] = 0;
         m_l[k] = 0;
      end
      m_lock = 0;
      m_dest = 0;
   endtask

   // called just after a falling edge; returns whether the beat was taken
   task automatic step(input bit v, input int sel, input int data,
                       input bit last, input logic [3:0] rdy,
                       output bit acc);
      int tgt;
      bit e_rdy;
      i_valid = v;
      {i_sel1, i_sel0} = 2'(sel);
      i_data = W'(data);
      i_last = last;
      {i_ready3, i_ready2, i_ready1, i_ready0} = rdy;
      #1;
      tgt = m_lock ? m_dest : sel;
      e_rdy = !m_v[tgt] || rdy[tgt];
      chk("ready", 32'(o_ready), 32'(e_rdy));
      @(posedge i_clk);
      acc = v && e_rdy;
      for (int k = 0; k < 4; k++) begin
         if (acc && tgt == k) begin
            m_v[k] = 1;
            m_y[k] = data % (1 << W);
            m_l[k] = last;
         end else if (m_v[k] && rdy[k]) begin
            m_v[k] = 0;
         end
      end
      if (acc) begin
         if (!m_lock && !last) begin
            m_lock = 1;
            m_dest = tgt;
         end else if (m_lock && last) begin
            m_lock = 0;
            m_dest = 0;
         end
      end
      @(negedge i_clk);
      check_outputs();
   endtask

   task automatic st(input bit v, input int sel, input int data,
                     input bit last, input logic [3:0] rdy);
      bit a;
      step(v, sel, data, last, rdy, a);
   endtask

   initial begin
      bit a;
      bit pend;
      int ps, pd;
      bit pl;
      logic [3:0] r;

      i_rst_n = 1'b0;
      i_valid = 0; i_sel0 = 0; i_sel1 = 0; i_data = '0; i_last = 0;
      {i_ready3, i_ready2, i_ready1, i_ready0} = 4'h0;
      model_reset();
      repeat (3) @(negedge i_clk);
      check_outputs();
      i_rst_n = 1'b1;

      // single-beat packets to every port
      st(1, 0, 1, 1, 4'hF);
      st(1, 1, 2, 1, 4'hF);
      st(1, 2, 3, 1, 4'hF);
      st(1, 3, 0, 1, 4'hF);
      st(0, 0, 0, 0, 4'hF);

      // select changes mid-packet are ignored
      st(1, 2, 1, 0, 4'hF);
      st(1, 1, 2, 0, 4'hF);
      st(1, 1, 3, 1, 4'hF);
      st(0, 1, 0, 0, 4'hF);

      // stalled port 2 does not block port 1
      st(1, 2, 1, 1, 4'b1011);
      st(1, 2, 2, 1, 4'b1011);
      st(1, 1, 3, 1, 4'b1011);
      st(1, 2, 2, 1, 4'hF);
      st(0, 0, 0, 0, 4'hF);

      // back-to-back beats to port 3
      for (int i = 0; i < 8; i++) st(1, 3, i, i == 7, 4'hF);
      st(0, 0, 0, 0, 4'hF);

      // same-cycle drain and refill on port 0
      st(1, 0, 1, 1, 4'h0);
      st(1, 0, 2, 1, 4'h1);
      st(0, 0, 0, 0, 4'hF);

      // reset in the middle of a port-1 packet
      st(1, 1, 1, 0, 4'hF);
      st(1, 1, 2, 0, 4'hF);
      i_rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", 32'({o_valid3, o_valid2, o_valid1, o_valid0}), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_dest", 32'(o_dest), 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      st(1, 3, 2, 1, 4'hF);
      st(0, 0, 0, 0, 4'hF);

      // random traffic; beats held stable while stalled
      pend = 0; ps = 0; pd = 0; pl = 0;
      for (int c = 0; c < 400; c++) begin
         r = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
         if (!pend) begin
            ps = $urandom_range(0, 3);
            pd = $urandom_range(0, 3);
            pl = ($urandom_range(0, 3) == 0);
            pend = ($urandom_range(0, 3) != 0);
         end
         step(pend, ps, pd, pl, r, a);
         if (a) pend = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
